phy_tx_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that shares one PHY TX user AXI-stream port between `P_CH_NUM` requesters. It sits between the user-side stream sources and `phy_tx`, and grants the port to one source at a time for a whole packet (first beat through `last`). After each packet it enforces a configurable idle gap so that `phy_tx` returns to idle before the next frame. It also holds off all traffic until the GT reports TX done.

---
 rtl/phy_tx_arb_pkg.sv | 19 +
 rtl/phy_tx_arbiter_rr_pick.sv | 42 ++++
 rtl/phy_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_phy_tx_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_arb_pkg
//  Description : Shared constants for the PHY TX packet arbiter: FSM state
//                encoding and PHY user-stream widths.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_tx_arb_pkg;

    localparam int P_PHY_DW = 32;   // PHY user data width
    localparam int P_PHY_KW = 4;    // PHY user keep width

    localparam logic [1:0] P_ARB_ST_ARB  = 2'd0;
    localparam logic [1:0] P_ARB_ST_XFER = 2'd1;
    localparam logic [1:0] P_ARB_ST_GAP  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/phy_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority picker. Returns a one-hot
//                grant for the first requester at or after i_ptr, wrapping.
//  Ports       : i_req   - request vector
//                i_ptr   - highest-priority channel index
//                o_grant - one-hot pick (zero when no request)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int P_CH_NUM = 4,
    parameter int P_PTR_W  = 2
) (
    input  logic [P_CH_NUM-1:0] i_req,
    input  logic [P_PTR_W-1:0]  i_ptr,
    output logic [P_CH_NUM-1:0] o_grant
);

    // Duplicating the request vector turns the wrap-around search into a
    // plain upward scan starting at i_ptr; the two halves are OR-folded back.
    logic [2*P_CH_NUM-1:0] w_req_dbl;
    logic [2*P_CH_NUM-1:0] w_pick_dbl;
    logic                  w_found;

    assign w_req_dbl = {i_req, i_req};

    always_comb begin
        w_pick_dbl = '0;
        w_found    = 1'b0;
        for (int i = 0; i < 2*P_CH_NUM; i++) begin
            if (!w_found && (i >= int'(i_ptr)) && w_req_dbl[i]) begin
                w_pick_dbl[i] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    assign o_grant = w_pick_dbl[P_CH_NUM-1:0] | w_pick_dbl[2*P_CH_NUM-1:P_CH_NUM];

endmodule
`default_nettype wire

// File: rtl/phy_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : phy_tx_arbiter
//  Description : Packet-atomic round-robin arbiter sharing one PHY TX user
//                AXI-stream port among P_CH_NUM sources, with an idle gap
//                after every packet and hold-off until GT TX done.
//  Ports       : i_clk, i_rst_n         - clock, async active-low reset
//                i_gt_tx_done           - GT TX ready, blocks traffic when low
//                i_s_valid/keep/data/last, o_s_ready - per-channel slave side
//                o_m_valid/keep/data/last, i_m_ready - master side to phy_tx
//                o_grant                - one-hot current owner
//                o_busy                 - high in XFER or GAP
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_tx_arbiter
    import phy_tx_arb_pkg::*;
#(
    parameter int P_CH_NUM     = 4,
    parameter int P_GAP_CYCLES = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_gt_tx_done,
    input  logic [P_CH_NUM-1:0]          i_s_valid,
    input  logic [P_CH_NUM*P_PHY_KW-1:0] i_s_keep,
    input  logic [P_CH_NUM*P_PHY_DW-1:0] i_s_data,
    input  logic [P_CH_NUM-1:0]          i_s_last,
    output logic [P_CH_NUM-1:0]          o_s_ready,
    output logic                         o_m_valid,
    output logic [P_PHY_KW-1:0]          o_m_keep,
    output logic [P_PHY_DW-1:0]          o_m_data,
    output logic                         o_m_last,
    input  logic                         i_m_ready,
    output logic [P_CH_NUM-1:0]          o_grant,
    output logic                         o_busy
);

    localparam int c_PTR_W = $clog2(P_CH_NUM);
    localparam int c_GAP_W = (P_GAP_CYCLES > 1) ? $clog2(P_GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST =
        c_GAP_W'((P_GAP_CYCLES > 0) ? (P_GAP_CYCLES - 1) : 0);
    localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(P_CH_NUM - 1);

    logic [1:0]          r_state,   w_state_nxt;
    logic [c_PTR_W-1:0]  r_ptr,     w_ptr_nxt;
    logic [c_GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
    logic [P_CH_NUM-1:0] r_grant,   w_grant_nxt;

    logic [P_CH_NUM-1:0] w_pick;
    logic                w_in_xfer;
    logic                w_link_ok;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [P_PHY_KW-1:0] w_sel_keep;
    logic [P_PHY_DW-1:0] w_sel_data;
    logic [c_PTR_W-1:0]  w_sel_idx;

    rr_pick #(
        .P_CH_NUM (P_CH_NUM),
        .P_PTR_W  (c_PTR_W)
    ) u_rr_pick (
        .i_req   (i_s_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick)
    );

    // AND-OR mux under the one-hot registered grant; a zero grant yields zeros.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_keep  = '0;
        w_sel_data  = '0;
        w_sel_idx   = '0;
        for (int k = 0; k < P_CH_NUM; k++) begin
            if (r_grant[k]) begin
                w_sel_valid = w_sel_valid | i_s_valid[k];
                w_sel_last  = w_sel_last  | i_s_last[k];
                w_sel_keep  = w_sel_keep  | i_s_keep[P_PHY_KW*k +: P_PHY_KW];
                w_sel_data  = w_sel_data  | i_s_data[P_PHY_DW*k +: P_PHY_DW];
                w_sel_idx   = w_sel_idx   | c_PTR_W'(k);
            end
        end
    end

    assign w_in_xfer = (r_state == P_ARB_ST_XFER);
    assign w_link_ok = i_m_ready & i_gt_tx_done;

    // Valid carries the same ready/gt qualifier as ready, so o_m_valid is
    // high exactly on cycles where a beat transfers.
    assign o_m_valid = w_in_xfer & w_sel_valid & w_link_ok;
    assign o_m_last  = w_in_xfer & w_sel_last;
    assign o_m_keep  = w_in_xfer ? w_sel_keep : '0;
    assign o_m_data  = w_in_xfer ? w_sel_data : '0;
    assign o_s_ready = (w_in_xfer && w_link_ok) ? r_grant : '0;
    assign o_grant   = r_grant;
    assign o_busy    = (r_state != P_ARB_ST_ARB);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gap_cnt_nxt = r_gap_cnt;
        w_grant_nxt   = r_grant;
        case (r_state)
            P_ARB_ST_ARB: begin
                // Waiting for i_m_ready also absorbs phy_tx's post-last busy time.
                if (i_gt_tx_done && i_m_ready && (|i_s_valid)) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = P_ARB_ST_XFER;
                end
            end
            P_ARB_ST_XFER: begin
                if (o_m_valid && w_sel_last) begin
                    w_ptr_nxt     = (w_sel_idx == c_PTR_MAX) ? '0 : (w_sel_idx + c_PTR_W'(1));
                    w_grant_nxt   = '0;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = (P_GAP_CYCLES == 0) ? P_ARB_ST_ARB : P_ARB_ST_GAP;
                end
            end
            P_ARB_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = P_ARB_ST_ARB;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + c_GAP_W'(1);
                end
            end
            default: begin
                w_grant_nxt   = '0;
                w_gap_cnt_nxt = '0;
                w_state_nxt   = P_ARB_ST_ARB;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= P_ARB_ST_ARB;
            r_ptr     <= '0;
            r_gap_cnt <= '0;
            r_grant   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_grant   <= w_grant_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_tx_arbiter
//  Description : Self-checking bench for phy_tx_arbiter (4 channels, gap 4).
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_tx_arbiter;

    localparam int c_N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          gt_done;
    logic [3:0]    s_valid;
    logic [15:0]   s_keep;
    logic [127:0]  s_data;
    logic [3:0]    s_last;
    logic [3:0]    s_ready;
    logic          m_valid;
    logic [3:0]    m_keep;
    logic [31:0]   m_data;
    logic          m_last;
    logic          m_ready;
    logic [3:0]    grant;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    phy_tx_arbiter #(.P_CH_NUM(4), .P_GAP_CYCLES(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_gt_tx_done (gt_done),
        .i_s_valid    (s_valid),
        .i_s_keep     (s_keep),
        .i_s_data     (s_data),
        .i_s_last     (s_last),
        .o_s_ready    (s_ready),
        .o_m_valid    (m_valid),
        .o_m_keep     (m_keep),
        .o_m_data     (m_data),
        .o_m_last     (m_last),
        .i_m_ready    (m_ready),
        .o_grant      (grant),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- source model (one packet script per channel) -------
    int m_len [c_N];
    int m_beat[c_N];
    int m_pkt [c_N];
    int m_left[c_N];
    bit m_pause[c_N];
    bit m_hs  [c_N];

    function automatic logic [31:0] mk_data(input int ch, input int pkt, input int beat);
        return {8'hD0 + 8'(ch), 8'(pkt), 16'(beat)};
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < c_N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < c_N; k++) begin
            m_len[k] = 1; m_beat[k] = 0; m_pkt[k] = 0; m_left[k] = 0;
            m_pause[k] = 1'b0; m_hs[k] = 1'b0;
        end
    endtask

    task automatic drive_model();
        for (int k = 0; k < c_N; k++) begin
            logic v, l;
            v = (m_left[k] > 0) && !m_pause[k];
            l = v && (m_beat[k] == m_len[k] - 1);
            s_valid[k]          = v;
            s_last[k]           = l;
            s_data[32*k +: 32]  = v ? mk_data(k, m_pkt[k], m_beat[k]) : 32'h0;
            s_keep[4*k +: 4]    = v ? (l ? 4'b1100 : 4'b1111) : 4'h0;
        end
    endtask

    task automatic capture_hs();
        for (int k = 0; k < c_N; k++) m_hs[k] = s_ready[k] && s_valid[k];
    endtask

    task automatic update_model();
        for (int k = 0; k < c_N; k++) begin
            if (m_hs[k]) begin
                m_beat[k]++;
                if (m_beat[k] == m_len[k]) begin
                    m_beat[k] = 0; m_pkt[k]++; m_left[k]--;
                end
            end
        end
    endtask

    // Checks every transferred beat against the model of the granted channel.
    task automatic mon_check();
        int g;
        if (m_valid) begin
            chk("mon_onehot", 32'($countones(grant)), 32'd1);
            g = oh_idx(grant);
            if (g >= 0) begin
                chk("mon_data", m_data, mk_data(g, m_pkt[g], m_beat[g]));
                chk("mon_ready", {28'h0, s_ready}, {28'h0, grant});
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; gt_done = 1'b1; m_ready = 1'b1;
        s_valid = '0; s_keep = '0; s_data = '0; s_last = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- table-driven vector record -------------------------
    typedef struct {
        logic        v;
        logic        l;
        logic [31:0] d;
        logic [3:0]  k;
        logic [3:0]  e_grant;
        logic        e_mv;
        logic [31:0] e_md;
        logic [3:0]  e_mk;
        logic        e_ml;
        logic [3:0]  e_rdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Channel 2, 5-beat packet, keep 1100 on last, gap of 4 cycles.
        vecs[0] = '{1'b1, 1'b0, 32'hA5A5_0000, 4'hF, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        for (int i = 1; i <= 4; i++)
            vecs[i] = '{1'b1, 1'b0, 32'hA5A5_0000 + 32'(i-1), 4'hF,
                        4'b0100, 1'b1, 32'hA5A5_0000 + 32'(i-1), 4'hF, 1'b0, 4'b0100, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'hA5A5_0004, 4'b1100, 4'b0100, 1'b1, 32'hA5A5_0004, 4'b1100, 1'b1, 4'b0100, 1'b1};
        for (int i = 6; i <= 9; i++)
            vecs[i] = '{1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0, 4'h0, 1'b0};

        // ---------------- reset state ------------------------------------
        do_reset();
        @(negedge clk);
        chk("rst_grant", {28'h0, grant}, 32'h0);
        chk("rst_ready", {28'h0, s_ready}, 32'h0);
        chk("rst_mvalid", {31'h0, m_valid}, 32'h0);
        chk("rst_mdata", m_data, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk); #1;

        // ---------------- table: single channel packet -------------------
        for (int i = 0; i < 11; i++) begin
            s_valid = {1'b0, vecs[i].v, 2'b00};
            s_last  = {1'b0, vecs[i].l, 2'b00};
            s_data  = {32'h0, vecs[i].d, 64'h0};
            s_keep  = {4'h0, vecs[i].k, 8'h0};
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), {28'h0, grant}, {28'h0, vecs[i].e_grant});
            chk($sformatf("vec%0d_mvalid", i), {31'h0, m_valid}, {31'h0, vecs[i].e_mv});
            chk($sformatf("vec%0d_mdata", i), m_data, vecs[i].e_md);
            chk($sformatf("vec%0d_mkeep", i), {28'h0, m_keep}, {28'h0, vecs[i].e_mk});
            chk($sformatf("vec%0d_mlast", i), {31'h0, m_last}, {31'h0, vecs[i].e_ml});
            chk($sformatf("vec%0d_ready", i), {28'h0, s_ready}, {28'h0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].e_busy});
            @(posedge clk); #1;
        end

        // ---------------- round robin, all channels busy -----------------
        begin
            int order[$];
            int exp_order[5] = '{0, 1, 2, 3, 0};
            logic [3:0] prev_grant = '0;
            int last_cyc = -1;
            bit done = 1'b0;
            do_reset();
            for (int k = 0; k < c_N; k++) begin m_len[k] = 3; m_left[k] = 1; end
            m_left[0] = 2;
            for (int c = 0; c < 200 && !done; c++) begin
                drive_model();
                @(negedge clk);
                mon_check();
                if (grant != 4'h0 && prev_grant == 4'h0) order.push_back(oh_idx(grant));
                if (m_valid) begin
                    int g = oh_idx(grant);
                    if (g >= 0 && m_beat[g] == 0 && last_cyc >= 0)
                        chk("rr_spacing_ge5", {31'h0, (c - last_cyc) >= 5}, 32'h1);
                    if (m_last) last_cyc = c;
                end
                prev_grant = grant;
                capture_hs();
                @(posedge clk); #1;
                update_model();
                done = (m_left[0] + m_left[1] + m_left[2] + m_left[3]) == 0;
            end
            chk("rr_completed", {31'h0, done}, 32'h1);
            chk("rr_grant_count", 32'(order.size()), 32'd5);
            for (int i = 0; i < 5; i++)
                if (i < order.size()) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        end

        // ---------------- gt_tx_done hold-off ----------------------------
        do_reset();
        gt_done = 1'b0;
        m_len[1] = 2; m_left[1] = 1;
        for (int c = 0; c < 20; c++) begin
            drive_model();
            @(negedge clk);
            chk("gt_hold_grant", {28'h0, grant}, 32'h0);
            chk("gt_hold_ready", {28'h0, s_ready}, 32'h0);
            capture_hs();
            @(posedge clk); #1;
            update_model();
        end
        gt_done = 1'b1;
        drive_model();
        @(negedge clk);
        chk("gt_c20_grant", {28'h0, grant}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("gt_c21_grant", {28'h0, grant}, 32'h2);

        // ---------------- mid-packet back-pressure -----------------------
        begin
            int n_xf = 0;
            do_reset();
            m_len[0] = 4; m_left[0] = 1;
            for (int c = 0; c < 20; c++) begin
                m_ready = !(c == 3 || c == 4);
                drive_model();
                @(negedge clk);
                mon_check();
                if (m_valid) n_xf++;
                if (c == 3 || c == 4) begin
                    chk("bp_hold_data", m_data, mk_data(0, 0, 2));
                    chk("bp_stall_valid", {31'h0, m_valid}, 32'h0);
                    chk("bp_grant", {28'h0, grant}, 32'h1);
                end
                capture_hs();
                @(posedge clk); #1;
                update_model();
            end
            m_ready = 1'b1;
            chk("bp_total_beats", 32'(n_xf), 32'd4);
        end

        // ---------------- owner drops valid, channel 3 waiting -----------
        do_reset();
        m_len[0] = 4; m_left[0] = 1;
        m_len[3] = 2; m_left[3] = 1;
        for (int c = 0; c <= 14; c++) begin
            m_pause[0] = (c >= 2 && c <= 4);
            drive_model();
            @(negedge clk);
            mon_check();
            if (c >= 2 && c <= 4) chk("drop_grant_kept", {28'h0, grant}, 32'h1);
            if (c < 13)  chk("drop_ch3_ready_low", {31'h0, s_ready[3]}, 32'h0);
            if (c == 13) begin
                chk("drop_ch3_ready", {31'h0, s_ready[3]}, 32'h1);
                chk("drop_ch3_grant", {28'h0, grant}, 32'h8);
            end
            capture_hs();
            @(posedge clk); #1;
            update_model();
        end

        // ---------------- reset mid-packet -------------------------------
        begin
            bit found = 1'b0;
            do_reset();
            m_len[1] = 2; m_left[1] = 1;
            for (int c = 0; c < 12; c++) begin
                drive_model();
                @(negedge clk);
                mon_check();
                capture_hs();
                @(posedge clk); #1;
                update_model();
            end
            m_len[2] = 4; m_left[2] = 1;
            for (int c = 0; c < 20 && !found; c++) begin
                drive_model();
                @(negedge clk);
                if (m_valid && grant == 4'b0100 && m_beat[2] == 1) begin
                    found = 1'b1;
                end else begin
                    capture_hs();
                    @(posedge clk); #1;
                    update_model();
                end
            end
            chk("rst_mid_reached", {31'h0, found}, 32'h1);
            rst_n = 1'b0;
            #1;
            chk("rstmid_grant", {28'h0, grant}, 32'h0);
            chk("rstmid_ready", {28'h0, s_ready}, 32'h0);
            chk("rstmid_mvalid", {31'h0, m_valid}, 32'h0);
            chk("rstmid_mdata", m_data, 32'h0);
            chk("rstmid_mkeep", {28'h0, m_keep}, 32'h0);
            chk("rstmid_mlast", {31'h0, m_last}, 32'h0);
            chk("rstmid_busy", {31'h0, busy}, 32'h0);
            model_clear();
            drive_model();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            for (int k = 0; k < c_N; k++) begin m_len[k] = 1; m_left[k] = 1; end
            drive_model();
            @(negedge clk);
            chk("rstrel_arb_grant", {28'h0, grant}, 32'h0);
            capture_hs();
            @(posedge clk); #1;
            update_model();
            drive_model();
            @(negedge clk);
            chk("rstrel_ptr0_winner", {28'h0, grant}, 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
